// File: rtl/vga_scanout.sv
// vga_scanout: 1bpp framebuffer reader producing 640x480@60Hz monochrome video from clk_50mhz.
// Ports: clk_50mhz/reset (sync, active-high); vga_slot marks RAM cycles owned by scanout;
// ram_addr/ram_data form the read port (1-cycle latency); hsync/vsync active-low; blank is high
// outside the visible area; pixel is the video bit; underrun is sticky on an empty-FIFO pop.
// Optional VGA_FRAME_IRQ_EN adds frame_irq (set at start of vertical blank) and irq_ack.
module vga_scanout #(
  parameter int ADDR_W = 19,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  output logic              vga_slot,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              pixel,
`ifdef VGA_FRAME_IRQ_EN
  output logic              frame_irq,
  input  logic              irq_ack,
`endif
  output logic              underrun
);
  logic phase_q, hs_q, hs_d, vs_q, vs_d, bl_q, bl_d, ur_q, ur_d;
  logic [9:0] h_q, h_d, v_q, v_d, v_nxt;
  logic [6:0] rem_q, rem_d;
  logic [15:0] off_q, off_d;
  logic [7:0] f0_q, f0_d, f1_q, f1_d, sh_q, sh_d;
  logic [1:0] cnt_q, cnt_d, c1;
  logic pix_en, h_end, vis, fetch, reload, pop, pop_ok;
  assign pix_en = phase_q;
  assign h_end = h_q == 10'd799;
  assign v_nxt = v_q == 10'd524 ? 10'd0 : v_q + 10'd1;
  assign vis = h_q < 10'd640 && v_q < 10'd480;
  assign fetch = phase_q && rem_q != 7'd0 && cnt_q < 2'd2;
  assign reload = pix_en && h_q == 10'd640 && v_nxt < 10'd480;
  assign pop = pix_en && vis && h_q[2:0] == 3'd0;
  assign pop_ok = pop && cnt_q != 2'd0;
  // occupancy after the pop, i.e. the slot a same-cycle push lands in
  assign c1 = cnt_q - 2'(pop_ok);
  always_comb begin
    h_d = pix_en ? (h_end ? 10'd0 : h_q + 10'd1) : h_q;
    v_d = pix_en && h_end ? v_nxt : v_q;
    // reload and a completing fetch can coincide only right after reset; the fetch still counts
    rem_d = (reload ? 7'd80 : rem_q) - 7'(fetch);
    off_d = (reload && v_nxt == 10'd0 ? 16'd0 : off_q) + 16'(fetch);
    f0_d = fetch && c1 == 2'd0 ? ram_data : pop_ok ? f1_q : f0_q;
    f1_d = fetch && c1 == 2'd1 ? ram_data : f1_q;
    cnt_d = c1 + 2'(fetch);
    sh_d = pop ? (pop_ok ? f0_q : 8'h00) : pix_en && vis ? {sh_q[6:0], 1'b0} : sh_q;
    ur_d = ur_q | (pop && !pop_ok);
    // timing outputs lag the counters by one pixel, matching the shifter load
    hs_d = pix_en ? !(h_q >= 10'd656 && h_q < 10'd752) : hs_q;
    vs_d = pix_en ? !(v_q >= 10'd490 && v_q < 10'd492) : vs_q;
    bl_d = pix_en ? !vis : bl_q;
  end
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      phase_q <= 1'b0;
      h_q <= 10'd640;
      v_q <= 10'd524;
      rem_q <= 7'd80;
      off_q <= 16'd0;
      f0_q <= 8'h00;
      f1_q <= 8'h00;
      cnt_q <= 2'd0;
      sh_q <= 8'h00;
      ur_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b1;
    end else begin
      phase_q <= ~phase_q;
      h_q <= h_d;
      v_q <= v_d;
      rem_q <= rem_d;
      off_q <= off_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ur_q <= ur_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      bl_q <= bl_d;
    end
  end
`ifdef VGA_FRAME_IRQ_EN
  logic irq_q, irq_d;
  // set beats ack when both occur in one cycle
  assign irq_d = pix_en && h_end && v_q == 10'd479 ? 1'b1 : irq_ack ? 1'b0 : irq_q;
  always_ff @(posedge clk_50mhz) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign frame_irq = irq_q;
`endif
  assign vga_slot = phase_q;
  assign ram_addr = FB_BASE + ADDR_W'(off_q);
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign blank = bl_q;
  assign pixel = sh_q[7] & ~bl_q;
  assign underrun = ur_q;
endmodule
